demultiplexer_buffered_04: RTL and testbench
============================================

DEMULTIPLEXER_BUFFERED_04 -- requirements
Module: demultiplexer_buffered_04

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, as the data width of the input and of every output lane.
REQ-002 The block SHALL have parameter DEPTH, default 2, as the entries per lane buffer; legal values are powers of two, 2 or greater.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port IN_DATA, input, WIDTH bits: the word to route.
REQ-006 The block SHALL have port IN_SEL, input, 2 bits: the destination lane, where 00 selects A, 01 selects B, 10 selects C and 11 selects D.
REQ-007 The block SHALL have port IN_VALID, input, 1 bit: the source offers IN_DATA and IN_SEL.
REQ-008 The block SHALL have port IN_READY, output, 1 bit: the block accepts the offered word this cycle.
REQ-009 The block SHALL have ports A, B, C and D, each an output of WIDTH bits: the head word of each lane.
REQ-010 The block SHALL have ports VALID_A to VALID_D, each an output of 1 bit: the lane holds at least one word.
REQ-011 The block SHALL have ports READY_A to READY_D, each an input of 1 bit: the lane sink consumes the head word.

Function
REQ-012 An input transfer SHALL occur on a rising CLK edge when IN_VALID and IN_READY are both 1.
REQ-013 IN_READY SHALL be combinational from IN_SEL and the selected lane's fill count, and SHALL be 1 exactly when that lane holds fewer than DEPTH words.
- IN_READY does not depend on IN_VALID.
- IN_READY does not depend on any READY_x, so there is no combinational path from READY_x to IN_READY.
REQ-014 An accepted word SHALL appear on its lane output with VALID_x equal to 1 in the cycle after acceptance, giving 1-cycle latency; the block has no combinational IN_DATA-to-output path.
REQ-015 An output transfer on lane x SHALL occur on a rising CLK edge when VALID_x and READY_x are both 1; the head word is then removed.
REQ-016 While VALID_x is 1 and READY_x is 0, the lane x data and VALID_x SHALL hold stable.
REQ-017 Each lane SHALL deliver words in acceptance order; no ordering is defined between lanes.
REQ-018 Each lane SHALL keep a fill count of log2(DEPTH)+1 bits plus read and write pointers of log2(DEPTH) bits, and the pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 Count updates on each edge SHALL be as follows:
- push only: count increments by 1.
- pop only: count decrements by 1.
- push and pop together, at a count of 1 to DEPTH-1: count is unchanged, and both pointers advance.
REQ-020 A full lane SHALL refuse a push even when it pops in the same cycle; that push is retried next cycle.
REQ-021 An empty lane SHALL drive VALID_x equal to 0, and its data output SHALL show the stale head entry, which is don't-care.
REQ-022 A stall on one lane SHALL NOT block acceptance for the other lanes.
REQ-023 IN_SEL and IN_DATA SHALL be ignored when IN_VALID is 0, and a change of IN_SEL while stalled is legal: IN_READY follows the new lane.

Reset
REQ-024 RST equal to 1 SHALL immediately clear all fill counts and pointers and drive VALID_A to VALID_D to 0, independent of CLK.
REQ-025 Buffered words SHALL be discarded on reset, including reset asserted mid-transfer; the buffer storage itself is not reset.
REQ-026 During reset, IN_READY SHALL be 1 for every IN_SEL value, and no transfer SHALL occur on any edge while RST is 1.
REQ-027 The first transfer SHALL be possible on the first rising CLK edge after RST falls.

Structure
REQ-028 A shared package SHALL hold the default WIDTH and DEPTH and the lane-select constants LANE_A=2'b00, LANE_B=2'b01, LANE_C=2'b10 and LANE_D=2'b11.
REQ-029 The per-lane buffer SHALL be one sub-module, demux_lane_fifo, instantiated four times, with:
- ports CLK, RST, PUSH, PUSH_DATA, FULL, POP, HEAD and NOT_EMPTY.
- a 1-of-4 select decode at top level that gates PUSH.
REQ-030 Top-level RTL SHALL contain only the decode, the IN_READY mux and the instances.

Verification
REQ-031 Scenario: send A=4'b0001 (sel 00), B=4'b0010 (01), C=4'b0100 (10), D=4'b1000 (11) on consecutive cycles with all READY_x=1. Required: each lane presents its word with VALID_x=1 exactly one cycle after acceptance.
REQ-032 Scenario: hold READY_B=0 and send 4'h3, 4'h5 and 4'h7 to lane B. Required: IN_READY=0 on the third offer; releasing READY_B yields 4'h3 then 4'h5; 4'h7 is accepted on the cycle after the first pop.
REQ-033 Scenario: with lane B full and stalled, send 4'h9 to lane C. Required: it is accepted immediately and appears on C one cycle later.
REQ-034 Scenario: hold lane A at count 1 and push 4'hE while READY_A=1. Required: count stays 1 and A advances to 4'hE with no VALID_A bubble.
REQ-035 Scenario: assert RST mid-cycle with lanes A and D holding data. Required: VALID_A to VALID_D fall to 0 before the next edge, and after release the old words never reappear.
REQ-036 Scenario: run 200 random cycles of IN_VALID, IN_SEL and READY_x. Required: a scoreboard confirms per-lane order, no loss, no duplication, and VALID_x and data stable under stall.

Source files
------------

// File: rtl/demultiplexer_buffered_04_pkg.sv
// demultiplexer_buffered_04_pkg
//   Shared definitions for the buffered 1-to-4 demultiplexer: default data
//   width and per-lane buffer depth, and the lane-select encoding used on
//   IN_SEL.
package demultiplexer_buffered_04_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_DEPTH = 2;
    localparam int unsigned NUM_LANES     = 4;

    typedef enum logic [1:0] {
        LANE_A = 2'b00,
        LANE_B = 2'b01,
        LANE_C = 2'b10,
        LANE_D = 2'b11
    } lane_e;

endpackage

// File: rtl/demux_lane_fifo.sv
// demux_lane_fifo
//   One output lane buffer: a DEPTH-entry FIFO with valid/ready style flags.
//   Ports:
//     CLK        rising-edge clock
//     RST        asynchronous active-high reset (clears count and pointers)
//     PUSH       write request; ignored while FULL
//     PUSH_DATA  word to write
//     FULL       lane holds DEPTH words
//     POP        sink consumes the head word; ignored while empty
//     HEAD       word at the read pointer (stale when empty)
//     NOT_EMPTY  lane holds at least one word
module demux_lane_fifo
    import demultiplexer_buffered_04_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PUSH,
    input  logic [WIDTH-1:0] PUSH_DATA,
    output logic             FULL,
    input  logic             POP,
    output logic [WIDTH-1:0] HEAD,
    output logic             NOT_EMPTY
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0]      count;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A full lane refuses a push even if it pops on the same edge.
    assign FULL      = (count == (PW+1)'(DEPTH));
    assign NOT_EMPTY = (count != '0);
    assign do_push   = PUSH && !FULL;
    assign do_pop    = POP && NOT_EMPTY;
    assign HEAD      = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; reset only discards via the pointers.
    always_ff @(posedge CLK) begin
        if (do_push && !RST) mem[wr_ptr] <= PUSH_DATA;
    end

endmodule

// File: rtl/demultiplexer_buffered_04.sv
// demultiplexer_buffered_04
//   Routes one input word stream to four buffered output lanes (A..D) chosen
//   by IN_SEL. Each lane has its own FIFO so a stalled lane never blocks
//   the others. Output latency is one cycle; no combinational data path.
//   Ports:
//     CLK, RST                      clock, asynchronous active-high reset
//     IN_DATA, IN_SEL, IN_VALID     offered word and destination lane
//     IN_READY                      selected lane has room (independent of
//                                   IN_VALID and of every READY_x)
//     A, B, C, D                    head word of each lane
//     VALID_A..VALID_D              lane holds at least one word
//     READY_A..READY_D              lane sink consumes the head word
module demultiplexer_buffered_04
    import demultiplexer_buffered_04_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic [1:0]       IN_SEL,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic             VALID_A,
    output logic             VALID_B,
    output logic             VALID_C,
    output logic             VALID_D,
    input  logic             READY_A,
    input  logic             READY_B,
    input  logic             READY_C,
    input  logic             READY_D
);

    logic [NUM_LANES-1:0] lane_push;
    logic [NUM_LANES-1:0] lane_pop;
    logic [NUM_LANES-1:0] lane_full;
    logic [NUM_LANES-1:0] lane_ne;
    logic [WIDTH-1:0]     lane_head [NUM_LANES];

    assign lane_pop = {READY_D, READY_C, READY_B, READY_A};

    assign IN_READY = !lane_full[IN_SEL];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_push[i] = IN_VALID && IN_READY && (IN_SEL == 2'(i));

        demux_lane_fifo #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) u_fifo (
            .CLK       (CLK),
            .RST       (RST),
            .PUSH      (lane_push[i]),
            .PUSH_DATA (IN_DATA),
            .FULL      (lane_full[i]),
            .POP       (lane_pop[i]),
            .HEAD      (lane_head[i]),
            .NOT_EMPTY (lane_ne[i])
        );
    end

    assign A       = lane_head[LANE_A];
    assign B       = lane_head[LANE_B];
    assign C       = lane_head[LANE_C];
    assign D       = lane_head[LANE_D];
    assign VALID_A = lane_ne[LANE_A];
    assign VALID_B = lane_ne[LANE_B];
    assign VALID_C = lane_ne[LANE_C];
    assign VALID_D = lane_ne[LANE_D];

endmodule

// File: tb/tb_demultiplexer_buffered_04.sv
// tb_demultiplexer_buffered_04
//   Self-checking bench: per-lane expected-word queues filled when a word is
//   offered and the lane has room, drained by a negedge monitor that checks
//   VALID_x, head data, IN_READY and stall stability.
module tb_demultiplexer_buffered_04;
    import demultiplexer_buffered_04_pkg::*;

    localparam int W = 4;
    localparam int D = 2;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] IN_DATA = '0;
    logic [1:0]   IN_SEL = '0;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [W-1:0] A, B, C, Dout;
    logic         VALID_A, VALID_B, VALID_C, VALID_D;
    logic [3:0]   rdy = '0;

    logic [3:0]   dv;
    logic [W-1:0] dd [4];

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] q [4][$];

    demultiplexer_buffered_04 #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_DATA  (IN_DATA),
        .IN_SEL   (IN_SEL),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (Dout),
        .VALID_A  (VALID_A),
        .VALID_B  (VALID_B),
        .VALID_C  (VALID_C),
        .VALID_D  (VALID_D),
        .READY_A  (rdy[0]),
        .READY_B  (rdy[1]),
        .READY_C  (rdy[2]),
        .READY_D  (rdy[3])
    );

    always #10 CLK = ~CLK;

    assign dv    = {VALID_D, VALID_C, VALID_B, VALID_A};
    assign dd[0] = A;
    assign dd[1] = B;
    assign dd[2] = C;
    assign dd[3] = Dout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Entered and left at posedge+1. Offer is evaluated at posedge+7; the
    // accepted word joins the model queue just after the edge that takes it.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                         input logic [3:0] r, input int exp_rdy);
        logic model_rdy;
        logic acc;
        IN_VALID = v;
        IN_SEL   = s;
        IN_DATA  = d;
        rdy      = r;
        #6;
        model_rdy = (q[s].size() < D);
        check("in_ready_model", IN_READY, model_rdy);
        if (exp_rdy >= 0) check("in_ready_directed", IN_READY, exp_rdy[0]);
        acc = v && model_rdy;
        @(posedge CLK);
        #1;
        if (acc) q[s].push_back(d);
    endtask

    task automatic drain();
        for (int k = 0; k < 12; k++) cycle(1'b0, 2'b00, '0, 4'b1111, -1);
    endtask

    // Reset asserted mid-cycle with an offer pending; held across one edge.
    task automatic reset_mid();
        IN_VALID = 1'b1;
        IN_SEL   = LANE_A;
        IN_DATA  = 4'hF;
        rdy      = '0;
        #1 RST = 1'b1;
        #1;
        check("rst_valid_a", VALID_A, 1'b0);
        check("rst_valid_b", VALID_B, 1'b0);
        check("rst_valid_c", VALID_C, 1'b0);
        check("rst_valid_d", VALID_D, 1'b0);
        for (int s = 0; s < 4; s++) begin
            IN_SEL = 2'(s);
            #1;
            check($sformatf("rst_in_ready_sel%0d", s), IN_READY, 1'b1);
        end
        IN_SEL = LANE_A;
        for (int i = 0; i < 4; i++) q[i].delete();
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        IN_VALID = 1'b0;
    endtask

    // Output monitor: lane state vs. model, stall stability, model pops.
    logic [3:0]   stall_prev = '0;
    logic [W-1:0] held [4];
    logic         ev;
    always @(negedge CLK) begin
        if (RST) begin
            stall_prev = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                ev = (q[i].size() > 0);
                check($sformatf("valid_lane%0d", i), dv[i], ev);
                if (ev) check($sformatf("data_lane%0d", i), dd[i], q[i][0]);
                if (stall_prev[i]) begin
                    check($sformatf("stall_valid_lane%0d", i), dv[i], 1'b1);
                    check($sformatf("stall_data_lane%0d", i), dd[i], held[i]);
                end
                stall_prev[i] = dv[i] && !rdy[i];
                held[i]       = dd[i];
                if (ev && rdy[i]) void'(q[i].pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] r;
        // Reset state
        #5;
        check("por_valid", dv, 4'b0000);
        check("por_in_ready", IN_READY, 1'b1);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // One word per lane, all sinks ready
        cycle(1'b1, LANE_A, 4'b0001, 4'b1111, 1);
        cycle(1'b1, LANE_B, 4'b0010, 4'b1111, 1);
        cycle(1'b1, LANE_C, 4'b0100, 4'b1111, 1);
        cycle(1'b1, LANE_D, 4'b1000, 4'b1111, 1);
        drain();

        // Lane B stalled until full; lane C unaffected
        cycle(1'b1, LANE_B, 4'h3, 4'b1101, 1);
        cycle(1'b1, LANE_B, 4'h5, 4'b1101, 1);
        cycle(1'b1, LANE_B, 4'h7, 4'b1101, 0);
        cycle(1'b1, LANE_C, 4'h9, 4'b1101, 1);
        cycle(1'b1, LANE_B, 4'h7, 4'b1111, 0);
        cycle(1'b1, LANE_B, 4'h7, 4'b1111, 1);
        drain();

        // Simultaneous push and pop at count 1
        cycle(1'b1, LANE_A, 4'h5, 4'b1110, 1);
        cycle(1'b1, LANE_A, 4'hE, 4'b1111, 1);
        cycle(1'b0, LANE_A, 4'h0, 4'b1110, -1);
        check("a_after_swap_valid", VALID_A, 1'b1);
        check("a_after_swap_data", A, 4'hE);
        drain();

        // Reset while lanes A and D hold data
        cycle(1'b1, LANE_A, 4'hC, 4'b0000, 1);
        cycle(1'b1, LANE_D, 4'hD, 4'b0000, 1);
        reset_mid();
        cycle(1'b1, LANE_B, 4'h6, 4'b1111, 1);
        drain();

        // Random traffic
        repeat (200) begin
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 3) != 0);
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom), r, -1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
